// File: rtl/rsign_array.sv
// rsign_array: per-channel binarisation of window data against serially loaded signed thresholds.
// Optional RSIGN_TIE_HIGH_EN makes a tie (data == threshold) produce 1 instead of 0.

module rsign_lane #(
  parameter int WIN    = 9,
  parameter int DATA_W = 16,
  parameter int PARA_W = 16
) (
  input  logic [WIN-1:0][DATA_W-1:0] data,
  input  logic [PARA_W-1:0]          thr,
  output logic [WIN-1:0]             bits
);
  logic signed [DATA_W-1:0] thr_x;
  assign thr_x = DATA_W'($signed(thr));

  for (genvar j = 0; j < WIN; j++) begin : g_tap
`ifdef RSIGN_TIE_HIGH_EN
    assign bits[j] = $signed(data[j]) >= thr_x;
`else
    assign bits[j] = $signed(data[j]) > thr_x;
`endif
  end
endmodule

module rsign_array #(
  parameter int FM_DEPTH = 128,
  parameter int WIN      = 9,
  parameter int DATA_W   = 16,
  parameter int PARA_W   = 16
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    mode,
  input  logic [PARA_W-1:0]                       para_in,
  input  logic                                    para_vld,
  output logic                                    load_done,
  input  logic                                    data_e,
  input  logic [FM_DEPTH-1:0][WIN-1:0][DATA_W-1:0] data_in,
  input  logic [1:0]                              chs_macro_in,
  output logic [1:0]                              chs_macro_out,
  output logic                                    data_e_out,
  output logic [FM_DEPTH-1:0][WIN-1:0]            data_out
);
  localparam int CW = $clog2(FM_DEPTH);
  localparam logic [CW-1:0] LAST = CW'(FM_DEPTH - 1);

  typedef enum logic [1:0] {LOAD, LOADED, CALC} state_t;

  state_t                           state;
  logic [CW-1:0]                    cnt;
  logic [FM_DEPTH-1:0][PARA_W-1:0]  thr;
  logic [FM_DEPTH-1:0][WIN-1:0]     cmp;

  for (genvar i = 0; i < FM_DEPTH; i++) begin : g_ch
    rsign_lane #(.WIN(WIN), .DATA_W(DATA_W), .PARA_W(PARA_W)) u_lane (
      .data (data_in[i]),
      .thr  (thr[i]),
      .bits (cmp[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= LOAD;
      cnt           <= '0;
      thr           <= '0;
      load_done     <= 1'b0;
      data_out      <= '0;
      data_e_out    <= 1'b0;
      chs_macro_out <= 2'd0;
    end else begin
      chs_macro_out <= chs_macro_in;
      data_e_out    <= 1'b0;
      // load_done gates acceptance, so a partial table is never used
      if (mode && data_e && load_done) begin
        data_out   <= cmp;
        data_e_out <= 1'b1;
      end
      case (state)
        LOAD: begin
          if (mode) state <= CALC;
          else if (para_vld) begin
            thr[cnt] <= para_in;
            if (cnt == LAST) begin
              state     <= LOADED;
              load_done <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        LOADED: if (mode) state <= CALC;
        CALC: begin
          if (!mode) begin
            state     <= LOAD;
            cnt       <= '0;
            load_done <= 1'b0;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule
